// File: rtl/sll_seq.sv
// rtl/sll_seq.sv - sequential logical-left shifter, one power-of-two stage per clock (optional SLL_EARLY_EXIT_EN)
module sll_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z
);

  localparam int CW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [STAGES-1:0] amt_q, amt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  z_q, z_d;

  logic [WIDTH-1:0]  acc_shifted;
  logic              oversize;
  logic              last_stage;

  // Next-state and datapath: accept in IDLE, one shift stage per SHIFT cycle, single DONE cycle
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    amt_d       = amt_q;
    cnt_d       = cnt_q;
    z_d         = z_q;
    oversize    = |Y[WIDTH-1:STAGES];
    acc_shifted = amt_q[cnt_q] ? (acc_q << (32'd1 << cnt_q)) : acc_q;
`ifdef SLL_EARLY_EXIT_EN
    // Stop as soon as no higher shift bits remain to be processed.
    last_stage  = (cnt_q == CW'(STAGES - 1)) || (((amt_q >> cnt_q) >> 1) == '0);
`else
    last_stage  = (cnt_q == CW'(STAGES - 1));
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          // An oversize amount yields zero; clearing amt as well lets the
          // early-exit build finish after a single stage.
          acc_d   = oversize ? '0 : X;
          amt_d   = oversize ? '0 : Y[STAGES-1:0];
        end
      end
      S_SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q + 1'b1;
        if (last_stage) begin
          state_d = S_DONE;
          z_d     = acc_shifted;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_SHIFT);
  assign done  = (state_q == S_DONE);
  assign Z     = z_q;

endmodule
